// File: rtl/img_proc_pkg.sv
// img_proc_pkg: shared constants, widths and pipeline tag type for the image-processing blocks
package img_proc_pkg;
  localparam int PIPE_LAT = 3;
  localparam int GRAD_EXTRA = 3;
  typedef struct packed {
    logic valid;
    logic blank;
    logic eol;
  } pix_tag_t;
  function automatic int grad_width(input int w);
    return w + GRAD_EXTRA;
  endfunction
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/win_shift_3x3.sv
// win_shift_3x3: 3x3 window shift register with column/row counters.
// Ports: clk, rst_n (async active-low), valid_i (column triplet valid),
// din_r0_i/din_r1_i/din_r2_i (bottom/middle/top pixel), win_o[row][col] (col 0 newest),
// tag_o (valid, blank = column 0/1 of a line, eol = last column) aligned with win_o.
module win_shift_3x3
  import img_proc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COL_NUM = 1280,
  parameter int ROW_NUM = 720
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  input  logic [WIDTH-1:0]            din_r0_i,
  input  logic [WIDTH-1:0]            din_r1_i,
  input  logic [WIDTH-1:0]            din_r2_i,
  output logic [2:0][2:0][WIDTH-1:0]  win_o,
  output pix_tag_t                    tag_o
);
  localparam int CW = COL_NUM > 1 ? $clog2(COL_NUM) : 1;
  localparam int RW = ROW_NUM > 1 ? $clog2(ROW_NUM) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_NUM - 1);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0][2:0][WIDTH-1:0] win_q, win_d;
  logic [2:0][WIDTH-1:0] din;
  pix_tag_t tag_q;
  logic col_last;
  assign din = {din_r2_i, din_r1_i, din_r0_i};
  always_comb begin
    col_last = col_q == COL_LAST;
    col_d = !valid_i ? col_q : col_last ? '0 : col_q + 1'b1;
    row_d = !(valid_i && col_last) ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    win_d = valid_i ? {win_q[2][1:0], din[2], win_q[1][1:0], din[1], win_q[0][1:0], din[0]} : win_q;
  end
  // blank marks the pixel whose window still spans the previous line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      tag_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      tag_q <= '{valid: valid_i, blank: col_q <= CW'(1), eol: valid_i && col_last};
    end
  assign win_o = win_q;
  assign tag_o = tag_q;
endmodule

// File: rtl/sobel_edge_3x3.sv
// sobel_edge_3x3: 3-stage Sobel edge detector (window, gradients, magnitude).
// Ports: clk, rst_n (async active-low), valid_in, din_r0/din_r1/din_r2 (bottom/middle/top line),
// thresh (binarisation threshold), dout (saturated |Gx|+|Gy| or binary edge), valid_out, eol.
// Build option: define SOBEL_BINARY_EN for binary output (mag > thresh -> all ones, else 0).
module sobel_edge_3x3
  import img_proc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COL_NUM = 1280,
  parameter int ROW_NUM = 720
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din_r0,
  input  logic [WIDTH-1:0] din_r1,
  input  logic [WIDTH-1:0] din_r2,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] dout,
  output logic             valid_out,
  output logic             eol
);
  localparam int GW = grad_width(WIDTH);
  localparam logic [WIDTH-1:0] PIX_MAX = WIDTH'(sat_max(WIDTH));
  logic [2:0][2:0][WIDTH-1:0] win;
  pix_tag_t tag1, tag2_q;
  logic signed [GW-1:0] gx_d, gx_q, gy_d, gy_q;
  logic [GW-1:0] ax, ay;
  logic [GW:0] mag;
  logic [WIDTH-1:0] pix, dout_d, dout_q;
  logic valid_q, eol_q;
  win_shift_3x3 #(.WIDTH(WIDTH), .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM)) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_in),
    .din_r0_i (din_r0),
    .din_r1_i (din_r1),
    .din_r2_i (din_r2),
    .win_o    (win),
    .tag_o    (tag1)
  );
  // 1-2-1 weighted sum, middle term doubled
  function automatic logic signed [GW-1:0] wsum(input logic [WIDTH-1:0] a, b, c);
    return $signed(GW'(a) + (GW'(b) << 1) + GW'(c));
  endfunction
`ifndef SOBEL_BINARY_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif
  always_comb begin
    gx_d = wsum(win[0][0], win[1][0], win[2][0]) - wsum(win[0][2], win[1][2], win[2][2]);
    gy_d = wsum(win[0][2], win[0][1], win[0][0]) - wsum(win[2][2], win[2][1], win[2][0]);
    ax = gx_q[GW-1] ? -gx_q : gx_q;
    ay = gy_q[GW-1] ? -gy_q : gy_q;
    mag = {1'b0, ax} + {1'b0, ay};
`ifdef SOBEL_BINARY_EN
    pix = (mag > (GW+1)'(thresh)) ? PIX_MAX : '0;
`else
    pix = |mag[GW:WIDTH] ? PIX_MAX : mag[WIDTH-1:0];
`endif
    dout_d = !tag2_q.valid ? dout_q : tag2_q.blank ? '0 : pix;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gx_q    <= '0;
      gy_q    <= '0;
      tag2_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      tag2_q  <= tag1;
      dout_q  <= dout_d;
      valid_q <= tag2_q.valid;
      eol_q   <= tag2_q.eol;
    end
  assign dout = dout_q;
  assign valid_out = valid_q;
  assign eol = eol_q;
endmodule
